// File: rtl/uart_rx_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx_top
//  Purpose  : 8N1 UART receiver into a byte FIFO with a popped-byte hex display.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_top #(
    parameter int CLKS_PER_BIT = 100,
    parameter int IDLE_BITS    = 10,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       data_in,
    input  logic       display_next,
    output logic [3:0] data_out_msd,
    output logic [3:0] data_out_lsd,
    output logic       error,
    output logic       fifo_empty,
    output logic       fifo_full
);

    localparam int IDLE_CYCLES = IDLE_BITS * CLKS_PER_BIT;
    localparam int CNT_W       = $clog2(IDLE_CYCLES + 1);
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int OCC_W       = PTR_W + 1;

    localparam logic [2:0] S_WAIT_IDLE = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_DATA      = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_ERROR     = 3'd5;

    logic             rx_meta_q, rx_sync_q;
    logic             disp_meta_q, disp_sync_q, disp_prev_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic [7:0]       disp_q;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic w_half_tick, w_bit_tick, w_push;
    logic w_pop_req, w_do_pop, w_do_push;

    // Line syncs to idle-high so reset never looks like a start bit.
    always_ff @(posedge CLK) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            disp_meta_q <= 1'b0;
            disp_sync_q <= 1'b0;
            disp_prev_q <= 1'b0;
        end else begin
            rx_meta_q   <= data_in;
            rx_sync_q   <= rx_meta_q;
            disp_meta_q <= display_next;
            disp_sync_q <= disp_meta_q;
            disp_prev_q <= disp_sync_q;
        end
    end

    assign w_half_tick = (cnt_q == CNT_W'(CLKS_PER_BIT / 2 - 1));
    assign w_bit_tick  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= S_WAIT_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        case (state_q)
            S_WAIT_IDLE: begin
                if (!rx_sync_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(IDLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (!rx_sync_q) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (w_half_tick) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_sync_q ? S_ERROR : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_tick) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_tick) begin
                    cnt_d   = '0;
                    state_d = rx_sync_q ? S_IDLE : S_ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_WAIT_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        w_push = 1'b0;
        error  = 1'b0;
        case (state_q)
            S_STOP:  w_push = w_bit_tick & rx_sync_q;
            S_ERROR: error  = 1'b1;
            default: w_push = 1'b0;
        endcase
    end

    assign fifo_empty = (occ_q == '0);
    assign fifo_full  = (occ_q == OCC_W'(FIFO_DEPTH));

    // A full FIFO still accepts a byte when a pop frees a slot the same cycle.
    assign w_pop_req = disp_sync_q & ~disp_prev_q;
    assign w_do_pop  = w_pop_req & ~fifo_empty;
    assign w_do_push = w_push & (~fifo_full | w_do_pop);

    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            disp_q   <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                disp_q   <= mem_q[rd_ptr_q];
            end
            case ({w_do_push, w_do_pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign data_out_msd = disp_q[7:4];
    assign data_out_lsd = disp_q[3:0];

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_top
//  Purpose  : Randomized scoreboard bench for uart_rx_top with a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_top;

    localparam int CPB   = 100;
    localparam int DEPTH = 16;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       data_in = 1'b1;
    logic       display_next = 1'b0;
    logic [3:0] data_out_msd, data_out_lsd;
    logic       error, fifo_empty, fifo_full;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_q [$];
    logic [7:0] exp_q   [$];
    logic [7:0] disp_model = 8'h00;
    bit         model_err  = 1'b0;
    event       pop_ev;

    uart_rx_top #(.CLKS_PER_BIT(CPB), .IDLE_BITS(10), .FIFO_DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .data_in      (data_in),
        .display_next (display_next),
        .data_out_msd (data_out_msd),
        .data_out_lsd (data_out_lsd),
        .error        (error),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full)
    );

    always #5 CLK = ~CLK;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    task automatic tick(int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset(int n);
        reset        = 1'b1;
        data_in      = 1'b1;
        display_next = 1'b0;
        tick(n);
        reset = 1'b0;
        model_q.delete();
        model_err  = 1'b0;
        disp_model = 8'h00;
    endtask

    task automatic check_reset(string tag);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_empty"}, 32'(fifo_empty), 32'd1);
        check({tag, "_full"},  32'(fifo_full), 32'd0);
        check({tag, "_disp"},  32'({data_out_msd, data_out_lsd}), 32'd0);
    endtask

    task automatic check_flags(string tag);
        check({tag, "_error"}, 32'(error), 32'(model_err));
        check({tag, "_empty"}, 32'(fifo_empty), 32'(model_q.size() == 0));
        check({tag, "_full"},  32'(fifo_full), 32'(model_q.size() == DEPTH));
    endtask

    task automatic idle_bits(int bits);
        data_in = 1'b1;
        tick(bits * CPB);
    endtask

    // Serial frame: start, 8 data LSB first, stop; the model applies the
    // framing and capacity rules once the frame is on the wire.
    task automatic send_byte(logic [7:0] b, bit stop_ok);
        data_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            data_in = b[i];
            tick(CPB);
        end
        data_in = stop_ok;
        tick(CPB);
        data_in = 1'b1;
        tick(CPB / 4);
        if (!model_err) begin
            if (!stop_ok)
                model_err = 1'b1;
            else if (model_q.size() < DEPTH)
                model_q.push_back(b);
        end
    endtask

    task automatic press;
        display_next = 1'b1;
        tick(4);
        display_next = 1'b0;
        tick(4);
        if (model_q.size() > 0)
            disp_model = model_q.pop_front();
        exp_q.push_back(disp_model);
        ->pop_ev;
    endtask

    // Monitor: each completed press presents a display value to score.
    always begin
        @(pop_ev);
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("display", 32'({data_out_msd, data_out_lsd}), 32'(e));
        end
    end

    initial begin
        do_reset(5);
        tick(1);
        check_reset("por");

        // False start: a 62.5 ns glitch after idle qualification
        idle_bits(15);
        data_in = 1'b0;
        #62.5;
        data_in = 1'b1;
        tick(CPB);
        model_err = 1'b1;
        check_flags("false_start");

        do_reset(20);
        tick(1);
        check_reset("err_reset");

        idle_bits(12);
        send_byte(8'h55, 1'b0);
        check_flags("bad_stop");

        do_reset(4);
        idle_bits(12);
        for (int i = 0; i < 15; i++)
            send_byte(8'(i), 1'b1);
        check_flags("fill15");
        for (int i = 0; i < 16; i++)
            press();
        check_flags("drain15");

        do_reset(4);
        idle_bits(12);
        for (int i = 0; i < 17; i++)
            send_byte(8'($urandom), 1'b1);
        check_flags("overflow");
        for (int i = 0; i < 17; i++)
            press();
        check_flags("drain16");

        do_reset(4);
        idle_bits(12);
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) != 0)
                send_byte(8'($urandom), 1'b1);
            else
                press();
            check_flags("random");
        end
        while (model_q.size() > 0)
            press();
        check_flags("random_drain");

        // Reset partway through a frame drops the partial byte
        send_byte(8'hA7, 1'b1);
        data_in = 1'b0;
        tick(CPB * 4);
        do_reset(3);
        tick(1);
        check_reset("midframe");

        tick(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
